// File: rtl/rnd_num_gen.sv
// Galois-LFSR random word source with a 2-entry prefetch FIFO and a req/gnt/rvalid
// consumer port; one word per cycle sustained once the FIFO is full.
module rnd_num_gen #(
    parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468,
    parameter logic [31:0] POLY         = 32'h8020_0003
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        seed_we_i,
    input  logic [31:0] seed_i,
    input  logic        rnd_num_req_i,
    output logic        rnd_num_gnt_o,
    output logic        rnd_num_rvalid_o,
    output logic [31:0] rnd_num_o,
    output logic [1:0]  level_o
);

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e         state_q;
    logic [W-1:0]   lfsr_q;
    logic [W-1:0]   fifo_q [DEPTH];
    logic [1:0]     count_q;
    logic [W-1:0]   rnd_num_q;
    logic           rvalid_q;

    logic           gnt;
    logic           push;
    logic           wr_idx;
    logic [W-1:0]   lfsr_d;
    logic [W-1:0]   seed_sel;
    logic [1:0]     count_d;
    logic [W-1:0]   fifo_d [DEPTH];

    // Grant gated by reset so nothing is accepted while rst_ni is low.
    assign gnt      = rst_ni && rnd_num_req_i && (count_q != 2'd0) && !seed_we_i;
    assign push     = !seed_we_i && ((state_q == FILL) || gnt);
    assign lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
    assign seed_sel = (seed_i == 32'd0) ? SEED_DEFAULT : seed_i;
    assign wr_idx   = 1'(count_q - 2'(gnt));

    // Pop shifts the head out; the new word lands behind whatever remains.
    always_comb begin
        count_d = count_q;
        fifo_d  = fifo_q;
        if (push && !gnt) begin
            count_d = count_q + 2'd1;
        end else if (gnt && !push) begin
            count_d = count_q - 2'd1;
        end
        if (gnt) begin
            fifo_d[0] = fifo_q[1];
        end
        if (push) begin
            fifo_d[wr_idx] = lfsr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= FILL;
            lfsr_q    <= SEED_DEFAULT;
            count_q   <= 2'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rnd_num_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= gnt;
            if (gnt) begin
                rnd_num_q <= fifo_q[0];
            end
            if (seed_we_i) begin
                lfsr_q  <= seed_sel;
                count_q <= 2'd0;
                state_q <= FILL;
            end else begin
                if (push) begin
                    lfsr_q <= lfsr_d;
                end
                count_q <= count_d;
                fifo_q  <= fifo_d;
                case (state_q)
                    FILL:    if (count_d == 2'd2) state_q <= FULL;
                    FULL:    if (count_d != 2'd2) state_q <= FILL;
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign rnd_num_gnt_o    = gnt;
    assign rnd_num_rvalid_o = rvalid_q;
    assign rnd_num_o        = rnd_num_q;
    assign level_o          = count_q;

endmodule

// File: tb/tb_rnd_num_gen.sv
// Self-checking bench for rnd_num_gen: directed scenarios plus randomized traffic
// against a queue-based reference model of the prefetching generator.
module tb_rnd_num_gen;

    localparam logic [31:0] DEF  = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        seed_we_i;
    logic [31:0] seed_i;
    logic        rnd_num_req_i;
    logic        rnd_num_gnt_o;
    logic        rnd_num_rvalid_o;
    logic [31:0] rnd_num_o;
    logic [1:0]  level_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_lfsr;
    logic [31:0] m_q [$];
    logic [31:0] m_out;
    logic        m_rv;
    logic [31:0] got [$];

    always #5 clk = ~clk;

    rnd_num_gen dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .seed_we_i        (seed_we_i),
        .seed_i           (seed_i),
        .rnd_num_req_i    (rnd_num_req_i),
        .rnd_num_gnt_o    (rnd_num_gnt_o),
        .rnd_num_rvalid_o (rnd_num_rvalid_o),
        .rnd_num_o        (rnd_num_o),
        .level_o          (level_o)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction

    function automatic logic [31:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the combinational grant, then check the registered results.
    task automatic cyc(input logic rst, input logic req, input logic we, input logic [31:0] sd);
        logic exp_gnt;
        rst_ni        = rst;
        rnd_num_req_i = req;
        seed_we_i     = we;
        seed_i        = sd;
        #1;
        exp_gnt = rst && req && (m_q.size() != 0) && !we;
        chk("gnt", 32'(rnd_num_gnt_o), 32'(exp_gnt));
        @(posedge clk);
        if (!rst) begin
            m_lfsr = DEF;
            m_q.delete();
            m_out  = 32'd0;
            m_rv   = 1'b0;
        end else if (we) begin
            m_lfsr = (sd == 32'd0) ? DEF : sd;
            m_q.delete();
            m_rv   = 1'b0;
        end else begin
            m_rv = exp_gnt;
            if (exp_gnt) m_out = m_q.pop_front();
            if (m_q.size() < 2) begin
                m_q.push_back(m_lfsr);
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
        #1;
        chk("rvalid", 32'(rnd_num_rvalid_o), 32'(m_rv));
        chk("rnd_num", rnd_num_o, m_out);
        chk("level", 32'(level_o), 32'(m_q.size()));
        if (rnd_num_rvalid_o === 1'b1) got.push_back(rnd_num_o);
    endtask

    initial begin
        logic [31:0] sd;
        int          pulses;
        rst_ni = 1'b0; rnd_num_req_i = 1'b1; seed_we_i = 1'b0; seed_i = '0;
        m_lfsr = DEF; m_out = '0; m_rv = 1'b0;
        @(posedge clk); #1;

        // Reset with req held high, then idle refill 0 -> 1 -> 2.
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("reset_level", 32'(level_o), 32'd0);
        chk("reset_out", rnd_num_o, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("fill_lvl1", 32'(level_o), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("fill_lvl2", 32'(level_o), 32'd2);

        got.delete();
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0);
        chk("first_word", got_at(0), 32'hACE1_2468);
        chk("second_word", got_at(1), 32'h5670_9234);

        // Seed of 1 and a known sequence.
        cyc(1'b1, 1'b0, 1'b1, 32'h1);
        got.delete();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        chk("seed1_w0", got_at(0), 32'h0000_0001);
        chk("seed1_w1", got_at(1), 32'h8020_0003);
        chk("seed1_w2", got_at(2), 32'hC030_0002);

        // Zero seed falls back to the default.
        cyc(1'b1, 1'b0, 1'b1, 32'h0);
        got.delete();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        chk("seed0_w0", got_at(0), 32'hACE1_2468);
        chk("seed0_w1", got_at(1), 32'h5670_9234);

        // Sustained one-word-per-cycle burst from FULL.
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("burst_start_lvl", 32'(level_o), 32'd2);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, '0);
            if (rnd_num_rvalid_o === 1'b1 && level_o === 2'd2) pulses++;
        end
        chk("burst_pulses", 32'(pulses), 32'd20);

        // Seed write colliding with a request at level 2.
        sd = $urandom | 32'h1;
        cyc(1'b1, 1'b1, 1'b1, sd);
        chk("seedcol_lvl", 32'(level_o), 32'd0);
        got.delete();
        for (int i = 0; i < 6 && got.size() == 0; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        chk("seedcol_word", got_at(0), sd);

        // Mid-operation reset with req high at level 2.
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("midrst_rvalid", 32'(rnd_num_rvalid_o), 32'd0);
        chk("midrst_out", rnd_num_o, 32'd0);
        got.delete();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        chk("midrst_refill", got_at(0), 32'hACE1_2468);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            sd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0), sd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
